// File: rtl/iob_bus_merge_pkg.sv
// Shared types and width helpers for the iob_bus_merge codebase slice.
// Request bus layout  : {valid, addr[ADDR_W-1:0], wdata[DATA_W-1:0], wstrb[DATA_W/8-1:0]}
// Response bus layout : {rdata[DATA_W-1:0], ready}
package iob_bus_merge_pkg;

  // FSM encoding shared by the merger and anything that decodes its debug state.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } merge_state_t;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // Width of a packed native-bus request for the given field widths.
  function automatic int req_w(input int aw, input int dw);
    return 1 + aw + dw + dw / 8;
  endfunction

  // Width of a packed native-bus response for the given data width.
  function automatic int resp_w(input int dw);
    return dw + 1;
  endfunction

endpackage

// File: rtl/iob_bus_merge_rr_arb2.sv
// iob_rr_arb2: two-way round-robin arbiter with a one-hot combinational grant.
// The pointer holds the index of the last master granted; it resets to 1 so that
// master 0 wins the first tie after reset.
module iob_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic last;

  // A lone requester wins outright; on a tie the master not granted last wins.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Remember who was granted whenever a grant is actually taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= 1'b1;
    end else if (en && (|req)) begin
      last <= gnt[1];
    end
  end

endmodule

// File: rtl/iob_bus_merge.sv
// iob_bus_merge: merges the PicoRV32 instruction bus (m0) and data bus (m1) onto a
// single native-bus slave port with round-robin arbitration and one outstanding
// transaction. The slave request is fully registered.
// Optional feature macro: IOB_MERGE_TIMEOUT_EN adds a slave-timeout counter and the
// sticky timeout_err flag; without it BUSY waits forever and timeout_err is 0.
//
// Handshake: a master holds valid (and its fields) until it sees ready; ready is a
// one-cycle pulse returned combinationally in the slave-ready cycle, and the master
// drops valid in that cycle. The slave sees s_req.valid held with stable fields until
// it returns ready; ready while no request is outstanding is ignored.
module iob_bus_merge
  import iob_bus_merge_pkg::*;
#(
  parameter  int ADDR_W    = DEF_ADDR_W,
  parameter  int DATA_W    = DEF_DATA_W,
  parameter  int TIMEOUT_W = 8,
  localparam int REQ_W     = req_w(ADDR_W, DATA_W),
  localparam int RESP_W    = resp_w(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REQ_W-1:0]  m0_req,
  output logic [RESP_W-1:0] m0_resp,
  input  logic [REQ_W-1:0]  m1_req,
  output logic [RESP_W-1:0] m1_resp,
  output logic [REQ_W-1:0]  s_req,
  input  logic [RESP_W-1:0] s_resp,
  output logic              timeout_err,
  output logic              state_dbg
);

  merge_state_t      state;
  logic              grant;      // 0: m0 owns the slave, 1: m1 owns the slave
  logic [1:0]        gnt;
  logic              tmo_hit;
  logic              done;
  logic [DATA_W-1:0] done_rdata;

  iob_rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({m1_req[REQ_W-1], m0_req[REQ_W-1]}),
    .en  (state == IDLE),
    .gnt (gnt)
  );

`ifdef IOB_MERGE_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TMO_MAX = '1;

  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic                 tmo_err_q;

  assign tmo_hit     = (state == BUSY) && !s_resp[0] && (tmo_cnt == TMO_MAX);
  assign timeout_err = tmo_err_q;

  // Count BUSY cycles without slave ready; the count is zero on entry to BUSY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt   <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      if (state == IDLE) begin
        tmo_cnt <= '0;
      end else if (!s_resp[0] && !tmo_hit) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (tmo_hit) begin
        tmo_err_q <= 1'b1;
      end
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // A real slave ready takes priority over a timeout landing in the same cycle.
  assign done       = (state == BUSY) && (s_resp[0] || tmo_hit);
  assign done_rdata = s_resp[0] ? s_resp[RESP_W-1:1] : '0;

  assign m0_resp   = (done && !grant) ? {done_rdata, 1'b1} : '0;
  assign m1_resp   = (done &&  grant) ? {done_rdata, 1'b1} : '0;
  assign state_dbg = state;

  // Transaction FSM: latch the winner's request in IDLE, hold it in BUSY until done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      s_req <= '0;
      grant <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|gnt) begin
            s_req <= gnt[1] ? m1_req : m0_req;
            grant <= gnt[1];
            state <= BUSY;
          end
        end
        BUSY: begin
          if (done) begin
            s_req[REQ_W-1] <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
